popcount_scheduler: RTL and testbench
=====================================

# popcount_scheduler

Sequencing controller for the PopCount datapath in the residual-binarized compute path. It accepts one SIMD chunk of multi-level binary activations plus per-lane gamma weights per handshake and issues each chunk to PopCount with a one-cycle start pulse. It waits for PopCount's done, accumulates the results across SYNAPSE_FOLD chunks, and presents one accumulated neuron sum downstream with valid/ready backpressure.

## Interface
- WEIGHT_LEVELS, 2, residual binarization levels per lane
- SIMD_WIDTH, 4, lanes per chunk
- POPCOUNT_WIDTH, 8, width of PopCount result and of each gamma
- SYNAPSE_FOLD, 4, chunks accumulated per output (≥1)
- ACC_WIDTH, 16, accumulator width (≥ POPCOUNT_WIDTH)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  chunk available
- in_ready  out  1  controller can accept a chunk
- in_data  in  WEIGHT_LEVELS*SIMD_WIDTH  activation bits
- in_gamma  in  POPCOUNT_WIDTH*SIMD_WIDTH  gamma vector
- pc_start  out  1  one-cycle start pulse to PopCount
- pc_in  out  WEIGHT_LEVELS*SIMD_WIDTH  registered activation bits to PopCount
- pc_gamma  out  POPCOUNT_WIDTH*SIMD_WIDTH  registered gamma to PopCount
- pc_out  in  POPCOUNT_WIDTH  PopCount result, valid when pc_done=1
- pc_done  in  1  PopCount completion
- acc_valid  out  1  accumulated sum available
- acc_ready  in  1  downstream accepts sum
- acc_data  out  ACC_WIDTH  accumulated sum
- acc_ovf  out  1  sum saturated; qualified by acc_valid
- fold_idx  out  clog2(SYNAPSE_FOLD) (min 1)  index of current chunk

## Operation
- States: IDLE, ISSUE, WAIT, OUT. All outputs are registered or decoded from state.
- IDLE: in_ready=1.
  - On in_valid&in_ready, latch in_data→pc_in and in_gamma→pc_gamma; go to ISSUE.
- ISSUE: pc_start=1 for exactly this cycle; go to WAIT.
- WAIT: on pc_done, acc ← acc + zero-extended pc_out.
  - If fold_idx==SYNAPSE_FOLD-1, go to OUT.
  - Otherwise fold_idx++ and go to IDLE.
- OUT: acc_valid=1. acc_data and acc_ovf are held stable until acc_ready.
  - On acc_valid&acc_ready: acc←0, acc_ovf←0, fold_idx←0; go to IDLE.
- pc_in and pc_gamma are held constant from ISSUE until the next IDLE accept.
- Saturation: if the sum exceeds 2^ACC_WIDTH−1, acc clamps to all-ones and acc_ovf is set. acc_ovf stays set until the output handshake.
- pc_done outside WAIT is ignored: no accumulate, no state change.
- in_ready=0 in ISSUE, WAIT and OUT. The controller never stalls PopCount.
- SYNAPSE_FOLD=1: every done goes straight to OUT.

## Timing
- Reset values: state IDLE, in_ready=1, pc_start=0, pc_in=0, pc_gamma=0, acc_valid=0, acc_data=0, acc_ovf=0, fold_idx=0.
- Reset mid-operation: abandon the partial accumulation. The next cycle is IDLE with all reset values. A pc_done arriving after reset is ignored.
- Per-chunk timing, with the accept edge E0 and PopCount done latency L ≥ 1 cycles after the start cycle:
  - pc_start is high in the cycle after E0.
  - pc_done is sampled in WAIT.
  - State leaves WAIT on the edge that samples pc_done.
  - Minimum chunk period is L+2 cycles.
- acc_valid rises the cycle after the final pc_done. Output-to-next-accept costs 1 cycle (OUT→IDLE).
- A pc_done in the same cycle as the ISSUE pulse is ignored, because the state is not yet WAIT.

## Test plan
- Single chunk, FOLD=1:
  - Stimulus: in_data=8'b10110011, in_gamma=16'b1010101000110011; PopCount model returns 8'd23 two cycles after start.
  - Required: pc_start is a single one-cycle pulse; pc_in/pc_gamma equal the inputs until the next accept; acc_valid rises with acc_data=23 and acc_ovf=0.
- Full fold, FOLD=4:
  - Stimulus: pc_out sequence 3,5,7,1.
  - Required: acc_data=16 after the fourth done; fold_idx steps 0,1,2,3 then returns to 0 after the output handshake; exactly 4 pc_start pulses.
- Backpressure:
  - Stimulus: hold acc_ready=0 for 5 cycles during OUT while in_valid=1.
  - Required: acc_data stays stable; in_ready=0 and no pc_start for all 5 cycles; after acc_ready=1, IDLE accepts the waiting chunk the next cycle.
- Saturation:
  - Stimulus: ACC_WIDTH=9, FOLD=4, pc_out=255 four times.
  - Required: acc_data=511, acc_ovf=1; the next output window starts with acc_ovf=0.
- Reset mid-WAIT:
  - Stimulus: assert rst for 1 cycle after the second chunk is issued; PopCount done arrives 1 cycle later.
  - Required: all outputs at reset values, the late done is ignored, and a following 4-chunk run of 1,1,1,1 yields acc_data=4.
- Spurious done:
  - Stimulus: pulse pc_done in IDLE and in ISSUE with pc_out=99.
  - Required: acc is unchanged and fold_idx is unchanged.

Source files
------------

// File: rtl/popcount_scheduler.sv
// Sequencing controller for the PopCount datapath: accepts SIMD chunks, issues each with a
// one-cycle start pulse, accumulates SYNAPSE_FOLD results and hands the sum downstream.
module popcount_scheduler #(
   parameter int WEIGHT_LEVELS  = 2,
   parameter int SIMD_WIDTH     = 4,
   parameter int POPCOUNT_WIDTH = 8,
   parameter int SYNAPSE_FOLD   = 4,
   parameter int ACC_WIDTH      = 16,
   localparam int DW     = WEIGHT_LEVELS * SIMD_WIDTH,
   localparam int GW     = POPCOUNT_WIDTH * SIMD_WIDTH,
   localparam int FIDX_W = (SYNAPSE_FOLD > 1) ? $clog2(SYNAPSE_FOLD) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DW-1:0]             in_data,
   input  logic [GW-1:0]             in_gamma,
   output logic                      pc_start,
   output logic [DW-1:0]             pc_in,
   output logic [GW-1:0]             pc_gamma,
   input  logic [POPCOUNT_WIDTH-1:0] pc_out,
   input  logic                      pc_done,
   output logic                      acc_valid,
   input  logic                      acc_ready,
   output logic [ACC_WIDTH-1:0]      acc_data,
   output logic                      acc_ovf,
   output logic [FIDX_W-1:0]         fold_idx,
   output logic [1:0]                dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid is never withdrawn and the payload is held stable until that edge.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   localparam logic [FIDX_W-1:0] LAST_IDX = FIDX_W'(SYNAPSE_FOLD - 1);

   state_t                state_q, state_d;
   logic [DW-1:0]         pc_in_q, pc_in_d;
   logic [GW-1:0]         pc_gamma_q, pc_gamma_d;
   logic [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic                  ovf_q, ovf_d;
   logic [FIDX_W-1:0]     fold_q, fold_d;
   logic [ACC_WIDTH:0]    sum;

   // One extra bit catches the carry that triggers saturation.
   assign sum = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - POPCOUNT_WIDTH){1'b0}}, pc_out};

   always_comb begin
      state_d    = state_q;
      pc_in_d    = pc_in_q;
      pc_gamma_d = pc_gamma_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      fold_d     = fold_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               pc_in_d    = in_data;
               pc_gamma_d = in_gamma;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (pc_done) begin
               if (sum[ACC_WIDTH]) begin
                  acc_d = '1;
                  ovf_d = 1'b1;
               end else begin
                  acc_d = sum[ACC_WIDTH-1:0];
               end
               if (fold_q == LAST_IDX) begin
                  state_d = S_OUT;
               end else begin
                  fold_d  = fold_q + 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_OUT: begin
            if (acc_ready) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               fold_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_in_q    <= '0;
         pc_gamma_q <= '0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
         fold_q     <= '0;
      end else begin
         state_q    <= state_d;
         pc_in_q    <= pc_in_d;
         pc_gamma_q <= pc_gamma_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
         fold_q     <= fold_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign pc_start  = (state_q == S_ISSUE);
   assign acc_valid = (state_q == S_OUT);
   assign pc_in     = pc_in_q;
   assign pc_gamma  = pc_gamma_q;
   assign acc_data  = acc_q;
   assign acc_ovf   = ovf_q;
   assign fold_idx  = fold_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_popcount_scheduler.sv
// Directed bench for popcount_scheduler: three instances (FOLD=1, FOLD=4, FOLD=4 with a
// 9-bit accumulator) share stimulus; each scenario observes the instance selected by sel.
module tb_popcount_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        acc_ready = 1'b0;
   logic        pc_done = 1'b0;
   logic [7:0]  in_data = '0;
   logic [7:0]  pc_out = '0;
   logic [31:0] in_gamma = '0;

   int sel = 1;
   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int dbl_cnt = 0;
   logic prev_start = 1'b0;

   logic [2:0]  rdy_v, st_v, av_v, ov_v;
   logic [7:0]  pin0, pin1, pin2;
   logic [31:0] pg0, pg1, pg2;
   logic [15:0] ad0, ad1;
   logic [8:0]  ad2;
   logic        fi0;
   logic [1:0]  fi1, fi2;
   logic [1:0]  ds0, ds1, ds2;

   logic        cur_ready, cur_start, cur_valid, cur_ovf;
   logic [7:0]  cur_pin;
   logic [31:0] cur_pg;
   logic [15:0] cur_acc;
   logic [1:0]  cur_fi, cur_state;

   always #5 clk = ~clk;

   popcount_scheduler #(.SYNAPSE_FOLD(1), .ACC_WIDTH(16)) u_f1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_v[0]), .in_data(in_data),
      .in_gamma(in_gamma), .pc_start(st_v[0]), .pc_in(pin0), .pc_gamma(pg0), .pc_out(pc_out),
      .pc_done(pc_done), .acc_valid(av_v[0]), .acc_ready(acc_ready), .acc_data(ad0),
      .acc_ovf(ov_v[0]), .fold_idx(fi0), .dbg_state(ds0));

   popcount_scheduler #(.SYNAPSE_FOLD(4), .ACC_WIDTH(16)) u_f4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_v[1]), .in_data(in_data),
      .in_gamma(in_gamma), .pc_start(st_v[1]), .pc_in(pin1), .pc_gamma(pg1), .pc_out(pc_out),
      .pc_done(pc_done), .acc_valid(av_v[1]), .acc_ready(acc_ready), .acc_data(ad1),
      .acc_ovf(ov_v[1]), .fold_idx(fi1), .dbg_state(ds1));

   popcount_scheduler #(.SYNAPSE_FOLD(4), .ACC_WIDTH(9)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_v[2]), .in_data(in_data),
      .in_gamma(in_gamma), .pc_start(st_v[2]), .pc_in(pin2), .pc_gamma(pg2), .pc_out(pc_out),
      .pc_done(pc_done), .acc_valid(av_v[2]), .acc_ready(acc_ready), .acc_data(ad2),
      .acc_ovf(ov_v[2]), .fold_idx(fi2), .dbg_state(ds2));

   always_comb begin
      cur_ready = rdy_v[sel];
      cur_start = st_v[sel];
      cur_valid = av_v[sel];
      cur_ovf   = ov_v[sel];
      case (sel)
         0:       begin cur_pin = pin0; cur_pg = pg0; cur_acc = ad0; cur_fi = {1'b0, fi0}; cur_state = ds0; end
         1:       begin cur_pin = pin1; cur_pg = pg1; cur_acc = ad1; cur_fi = fi1; cur_state = ds1; end
         default: begin cur_pin = pin2; cur_pg = pg2; cur_acc = {7'b0, ad2}; cur_fi = fi2; cur_state = ds2; end
      endcase
   end

   // Start-pulse monitor on the selected instance; dbl_cnt counts pulses longer than a cycle.
   always @(negedge clk) begin
      if (cur_start) begin
         start_cnt++;
         if (prev_start) dbl_cnt++;
      end
      prev_start = cur_start;
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; pc_done = 1'b0; acc_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Offer one chunk, check the issue cycle, answer with pc_out=v after lat cycles.
   task automatic run_chunk(input logic [7:0] d, input logic [31:0] g, input logic [7:0] v,
                            input int lat, input bit spur);
      int n = 0;
      in_data = d; in_gamma = g; in_valid = 1'b1;
      while (!cur_ready && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (!cur_ready) begin
         errors++; $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", cur_ready, n);
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (cur_start !== 1'b1) begin errors++; $display("FAIL issue_start: got %0b exp 1", cur_start); end
      checks++;
      if (cur_pin !== d) begin errors++; $display("FAIL issue_pc_in: got %0h exp %0h", cur_pin, d); end
      checks++;
      if (cur_pg !== g) begin errors++; $display("FAIL issue_pc_gamma: got %0h exp %0h", cur_pg, g); end
      if (spur) begin
         pc_done = 1'b1; pc_out = 8'd99;
         @(negedge clk);
         pc_done = 1'b0;
         checks++;
         if (cur_state !== 2'd2) begin errors++; $display("FAIL spur_issue_state: got %0d exp 2", cur_state); end
         repeat (lat - 1) @(negedge clk);
      end else begin
         repeat (lat) @(negedge clk);
      end
      pc_done = 1'b1; pc_out = v;
      @(negedge clk);
      pc_done = 1'b0;
      checks++;
      if (cur_pin !== d) begin errors++; $display("FAIL hold_pc_in: got %0h exp %0h", cur_pin, d); end
   endtask

   task automatic take_output(input logic [15:0] exp_acc, input logic exp_ovf);
      int n = 0;
      while (!cur_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (cur_valid !== 1'b1) begin errors++; $display("FAIL out_timeout: acc_valid=%0b required 1", cur_valid); end
      checks++;
      if (cur_acc !== exp_acc) begin errors++; $display("FAIL out_data: got %0d exp %0d", cur_acc, exp_acc); end
      checks++;
      if (cur_ovf !== exp_ovf) begin errors++; $display("FAIL out_ovf: got %0b exp %0b", cur_ovf, exp_ovf); end
      acc_ready = 1'b1;
      @(negedge clk);
      acc_ready = 1'b0;
      checks++;
      if (cur_valid !== 1'b0) begin errors++; $display("FAIL out_drop: acc_valid=%0b exp 0", cur_valid); end
      checks++;
      if (cur_fi !== 2'd0) begin errors++; $display("FAIL out_fold_clear: got %0d exp 0", cur_fi); end
      checks++;
      if (cur_acc !== 16'd0) begin errors++; $display("FAIL out_acc_clear: got %0d exp 0", cur_acc); end
   endtask

   task automatic test_reset();
      do_reset();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         checks++;
         if ({cur_ready, cur_start, cur_valid, cur_ovf} !== 4'b1000) begin
            errors++; $display("FAIL reset_ctl[%0d]: got %b exp 1000", s, {cur_ready, cur_start, cur_valid, cur_ovf});
         end
         checks++;
         if ({cur_acc, cur_fi, cur_state} !== 20'd0) begin
            errors++; $display("FAIL reset_regs[%0d]: acc=%0d fi=%0d st=%0d exp all 0", s, cur_acc, cur_fi, cur_state);
         end
         checks++;
         if ({cur_pin, cur_pg} !== 40'd0) begin
            errors++; $display("FAIL reset_pc[%0d]: pc_in=%0h pc_gamma=%0h exp 0", s, cur_pin, cur_pg);
         end
      end
   endtask

   task automatic test_single_fold1();
      int s0, d0;
      sel = 0;
      do_reset();
      s0 = start_cnt; d0 = dbl_cnt;
      run_chunk(8'b10110011, 32'b1010101000110011, 8'd23, 2, 1'b0);
      checks++;
      if (cur_valid !== 1'b1) begin errors++; $display("FAIL f1_valid_rise: got %0b exp 1", cur_valid); end
      checks++;
      if (cur_pg !== 32'h0000AA33) begin errors++; $display("FAIL f1_hold_gamma: got %0h exp aa33", cur_pg); end
      checks++;
      if (start_cnt - s0 !== 1 || dbl_cnt - d0 !== 0) begin
         errors++; $display("FAIL f1_start_pulse: pulses=%0d long=%0d exp 1/0", start_cnt - s0, dbl_cnt - d0);
      end
      take_output(16'd23, 1'b0);
   endtask

   task automatic test_full_fold();
      logic [7:0] vals [4] = '{8'd3, 8'd5, 8'd7, 8'd1};
      int s0;
      sel = 1;
      do_reset();
      s0 = start_cnt;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cur_fi !== 2'(i)) begin errors++; $display("FAIL fold_idx_step%0d: got %0d exp %0d", i, cur_fi, i); end
         run_chunk(8'(8'h10 + i), 32'(32'hC0DE0000 + i), vals[i], i + 1, 1'b0);
      end
      checks++;
      if (cur_fi !== 2'd3) begin errors++; $display("FAIL fold_idx_out: got %0d exp 3", cur_fi); end
      checks++;
      if (start_cnt - s0 !== 4) begin errors++; $display("FAIL fold_starts: got %0d exp 4", start_cnt - s0); end
      take_output(16'd16, 1'b0);
   endtask

   task automatic test_backpressure();
      int s0;
      sel = 1;
      do_reset();
      for (int i = 0; i < 4; i++) run_chunk(8'h01, 32'h1, 8'd2, 2, 1'b0);
      s0 = start_cnt;
      in_data = 8'h5A; in_gamma = 32'h12345678; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cur_ready !== 1'b0 || cur_valid !== 1'b1 || cur_acc !== 16'd8) begin
            errors++; $display("FAIL bp_hold%0d: ready=%0b valid=%0b acc=%0d exp 0/1/8", i, cur_ready, cur_valid, cur_acc);
         end
         @(negedge clk);
      end
      checks++;
      if (start_cnt != s0) begin errors++; $display("FAIL bp_no_start: got %0d pulses exp 0", start_cnt - s0); end
      acc_ready = 1'b1;
      @(negedge clk);
      acc_ready = 1'b0;
      checks++;
      if (cur_ready !== 1'b1) begin errors++; $display("FAIL bp_idle: in_ready=%0b exp 1", cur_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (cur_start !== 1'b1 || cur_pin !== 8'h5A) begin
         errors++; $display("FAIL bp_accept: start=%0b pc_in=%0h exp 1/5a", cur_start, cur_pin);
      end
   endtask

   task automatic test_saturation();
      sel = 2;
      do_reset();
      for (int i = 0; i < 4; i++) run_chunk(8'hFF, 32'hFFFFFFFF, 8'd255, 1, 1'b0);
      take_output(16'd511, 1'b1);
      for (int i = 0; i < 4; i++) run_chunk(8'h03, 32'h3, 8'd1, 1, 1'b0);
      take_output(16'd4, 1'b0);
   endtask

   task automatic test_reset_mid_wait();
      sel = 1;
      do_reset();
      run_chunk(8'h0F, 32'hF, 8'd5, 2, 1'b0);
      in_data = 8'h11; in_gamma = 32'h22; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; pc_done = 1'b1; pc_out = 8'd50;
      checks++;
      if ({cur_ready, cur_start, cur_valid, cur_ovf} !== 4'b1000 || cur_state !== 2'd0) begin
         errors++; $display("FAIL rst_mid_ctl: rso=%b st=%0d exp 1000/0", {cur_ready, cur_start, cur_valid, cur_ovf}, cur_state);
      end
      checks++;
      if (cur_acc !== 16'd0 || cur_fi !== 2'd0 || cur_pin !== 8'd0 || cur_pg !== 32'd0) begin
         errors++; $display("FAIL rst_mid_regs: acc=%0d fi=%0d pin=%0h pg=%0h exp 0", cur_acc, cur_fi, cur_pin, cur_pg);
      end
      @(negedge clk);
      pc_done = 1'b0;
      checks++;
      if (cur_state !== 2'd0 || cur_fi !== 2'd0) begin
         errors++; $display("FAIL rst_late_done: st=%0d fi=%0d exp 0/0", cur_state, cur_fi);
      end
      for (int i = 0; i < 4; i++) run_chunk(8'(8'h20 + i), 32'(i), 8'd1, 2, 1'b0);
      take_output(16'd4, 1'b0);
   endtask

   task automatic test_spurious_done();
      sel = 1;
      do_reset();
      run_chunk(8'hA1, 32'hA1, 8'd10, 2, 1'b0);
      pc_done = 1'b1; pc_out = 8'd99;
      @(negedge clk);
      pc_done = 1'b0;
      checks++;
      if (cur_fi !== 2'd1 || cur_state !== 2'd0) begin
         errors++; $display("FAIL spur_idle: fi=%0d st=%0d exp 1/0", cur_fi, cur_state);
      end
      run_chunk(8'hA2, 32'hA2, 8'd20, 2, 1'b1);
      checks++;
      if (cur_fi !== 2'd2) begin errors++; $display("FAIL spur_fold: got %0d exp 2", cur_fi); end
      run_chunk(8'hA3, 32'hA3, 8'd30, 3, 1'b0);
      run_chunk(8'hA4, 32'hA4, 8'd40, 1, 1'b0);
      take_output(16'd100, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single_fold1();
      test_full_fold();
      test_backpressure();
      test_saturation();
      test_reset_mid_wait();
      test_spurious_done();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
